// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared types for the SRAM arbiter.
// FSM state encoding and the fixed channel assignment.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SETUP,
    ARB_ACCESS,
    ARB_TURN
  } arb_state_t;

  localparam int ARB_CH_SCREEN = 0;
  localparam int ARB_CH_CPU    = 1;
  localparam int ARB_CH_UP     = 2;
  localparam int ARB_CH_DMA    = 3;

endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: requester bus plus SRAM pins.
// slave = arbiter side, master = requesters and SRAM.
interface sram_arbiter_if #(
  parameter int NCH = 4,
  parameter int AW  = 19,
  parameter int DW  = 8
);
  logic [NCH-1:0]    req;
  logic [NCH-1:0]    we;
  logic [NCH*AW-1:0] addr;
  logic [NCH*DW-1:0] wdata;
  logic [NCH-1:0]    gnt;
  logic [NCH-1:0]    ack;
  logic [DW-1:0]     rdata;
  logic [AW-1:0]     va;
  logic [DW-1:0]     vd;
  logic [DW-1:0]     vd_o;
  logic              vd_oe;
  logic              n_vrd;
  logic              n_vwr;

  modport slave (
    input  req, we, addr, wdata, vd,
    output gnt, ack, rdata, va,
    output vd_o, vd_oe, n_vrd, n_vwr
  );

  modport master (
    output req, we, addr, wdata, vd,
    input  gnt, ack, rdata, va,
    input  vd_o, vd_oe, n_vrd, n_vwr
  );
endinterface

// File: rtl/sram_arbiter_rr_pick.sv
// sram_arbiter_rr_pick: combinational winner select.
// in: req, urgent, rr_ptr; out: win (one-hot), win_idx, any, hit_urgent.
module sram_arbiter_rr_pick #(
  parameter int NCH = 4,
  parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] urgent,
  input  logic [IW-1:0]  rr_ptr,
  output logic [NCH-1:0] win,
  output logic [IW-1:0]  win_idx,
  output logic           any,
  output logic           hit_urgent
);
  logic [NCH-1:0] ureq;
  logic           found;
  logic [IW-1:0]  idx;
  int             j;

  always_comb begin
    ureq       = req & urgent;
    win        = '0;
    win_idx    = '0;
    found      = 1'b0;
    idx        = '0;
    j          = 0;
    any        = |req;
    hit_urgent = |ureq;
    if (hit_urgent) begin
      for (int i = 0; i < NCH; i++) begin
        if (ureq[i] && !found) begin
          found   = 1'b1;
          win_idx = IW'(i);
        end
      end
    end else begin
      // cyclic scan starting at rr_ptr
      for (int k = 0; k < NCH; k++) begin
        j = int'(rr_ptr) + k;
        if (j >= NCH) j = j - NCH;
        idx = IW'(j);
        if (req[idx] && !found) begin
          found   = 1'b1;
          win_idx = idx;
        end
      end
    end
    if (found) win[win_idx] = 1'b1;
  end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: N-channel arbiter/sequencer for the shared SRAM.
// clk28/rst plain; bus (slave) carries req/we/addr/wdata/gnt/ack/rdata + SRAM pins.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int AW         = 19,
  parameter int DW         = 8,
  parameter int ACC_CYCLES = 2,
  parameter logic [NCH-1:0] URGENT_MASK = {{(NCH-1){1'b0}}, 1'b1}
) (
  input logic           clk28,
  input logic           rst,
  sram_arbiter_if.slave bus
);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;

  arb_state_t     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [NCH-1:0] cur_q, cur_d;
  logic           we_q, we_d;
  logic [IW-1:0]  rr_q, rr_d;
  logic [NCH-1:0] gnt_q, gnt_d;
  logic [NCH-1:0] ack_q, ack_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic [AW-1:0]  va_q, va_d;
  logic [DW-1:0]  vd_o_q, vd_o_d;
  logic           vd_oe_q, vd_oe_d;
  logic           n_vrd_q, n_vrd_d;
  logic           n_vwr_q, n_vwr_d;

  logic           last;
  logic           take;
  logic [NCH-1:0] done;
  logic [NCH-1:0] pend;
  logic [NCH-1:0] win;
  logic [IW-1:0]  win_idx;
  logic           any;
  logic           hit_urgent;

  assign last = (state_q == ARB_ACCESS) &&
                (cnt_q == CW'(ACC_CYCLES - 1));

  // The channel being acked still shows req this cycle;
  // keep it out so it is not re-granted on a stale level.
  assign done = last ? cur_q : ack_q;
  assign pend = bus.req & ~done;

  sram_arbiter_rr_pick #(
    .NCH (NCH),
    .IW  (IW)
  ) u_pick (
    .req        (pend),
    .urgent     (URGENT_MASK),
    .rr_ptr     (rr_q),
    .win        (win),
    .win_idx    (win_idx),
    .any        (any),
    .hit_urgent (hit_urgent)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    we_d    = we_q;
    rr_d    = rr_q;
    gnt_d   = '0;
    ack_d   = '0;
    rdata_d = rdata_q;
    va_d    = va_q;
    vd_o_d  = vd_o_q;
    vd_oe_d = vd_oe_q;
    n_vrd_d = n_vrd_q;
    n_vwr_d = n_vwr_q;
    take    = 1'b0;
    unique case (state_q)
      ARB_IDLE: take = any;
      ARB_SETUP: begin
        state_d = ARB_ACCESS;
        cnt_d   = '0;
        n_vrd_d = we_q;
        n_vwr_d = ~we_q;
      end
      ARB_ACCESS: begin
        if (last) begin
          n_vrd_d = 1'b1;
          n_vwr_d = 1'b1;
          ack_d   = cur_q;
          if (we_q) begin
            state_d = ARB_TURN;
            vd_oe_d = 1'b0;
          end else begin
            rdata_d = bus.vd;
            state_d = ARB_IDLE;
            take    = any;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ARB_TURN: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
    if (take) begin
      state_d = ARB_SETUP;
      gnt_d   = win;
      cur_d   = win;
      we_d    = bus.we[win_idx];
      va_d    = bus.addr[int'(win_idx)*AW +: AW];
      vd_o_d  = bus.wdata[int'(win_idx)*DW +: DW];
      vd_oe_d = bus.we[win_idx];
      if (!hit_urgent) begin
        rr_d = (win_idx == IW'(NCH - 1)) ?
               '0 : win_idx + IW'(1);
      end
    end
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      we_q    <= 1'b0;
      rr_q    <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      va_q    <= '0;
      vd_o_q  <= '0;
      vd_oe_q <= 1'b0;
      n_vrd_q <= 1'b1;
      n_vwr_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      we_q    <= we_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      va_q    <= va_d;
      vd_o_q  <= vd_o_d;
      vd_oe_q <= vd_oe_d;
      n_vrd_q <= n_vrd_d;
      n_vwr_q <= n_vwr_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.va    = va_q;
  assign bus.vd_o  = vd_o_q;
  assign bus.vd_oe = vd_oe_q;
  assign bus.n_vrd = n_vrd_q;
  assign bus.n_vwr = n_vwr_q;

endmodule
